fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the RV32I core; successor to the pc_reg/pc_mux/instr_mem path.
//  Replaces gated-clock trigger start with a clean run/idle FSM, drives a 1-cycle-latency sync instruction memory,
//  buffers fetched words in a DEPTH-entry prefetch queue, hands {instr, pc} to decode via valid/ready.
//  Accepts branch/jump redirects from execute, flushing all wrong-path state.
// PARAMETERS
//  DATA_WIDTH   32     width of pc, instruction and memory address
//  RESET_PC     32'h0  first fetch address after reset
//  QUEUE_DEPTH  4      prefetch entries; power of 2, >= 2
// PORTS
//  clk              in   1            single clock, all state on posedge
//  rst              in   1            synchronous, active-high reset
//  trigger_i        in   1            start request; sampled each cycle while IDLE
//  redirect_i       in   1            taken branch/JAL/JALR from execute
//  redirect_pc_i    in   DATA_WIDTH   redirect target; bits[1:0] forced to 0
//  imem_req_o       out  1            fetch request this cycle
//  imem_addr_o      out  DATA_WIDTH   fetch address (valid when imem_req_o)
//  imem_instr_i     in   DATA_WIDTH   instruction word, valid the cycle after imem_req_o
//  instr_valid_o    out  1            head entry available to decode
//  instr_ready_i    in   1            decode accepts head entry
//  instr_o          out  DATA_WIDTH   head instruction; NOP 32'h0000_0013 when !instr_valid_o
//  pc_o             out  DATA_WIDTH   head pc; 0 when !instr_valid_o
//  pc_plus_4_o      out  DATA_WIDTH   pc_o + 4 (modulo 2^DATA_WIDTH), for JAL/JALR link
//  running_o        out  1            FSM in RUN
//  occupancy_o      out  $clog2(QUEUE_DEPTH)+1  stored entries + in-flight request
// BEHAVIOUR
//  Reset (rst high at posedge): state=IDLE, fetch_pc=RESET_PC, queue empty, inflight=0; outputs: imem_req_o=0,
//   imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=NOP, pc_o=0, running_o=0, occupancy_o=0. rst beats all inputs.
//  FSM: IDLE -> RUN on any posedge with trigger_i=1 and rst=0; RUN holds until rst. No other transitions.
//  IDLE: no requests; redirect_i loads fetch_pc only.
//  Issue (RUN): imem_req_o = !redirect_i && (count + inflight - pop) < QUEUE_DEPTH; pop = instr_valid_o && instr_ready_i.
//   On issue fetch_pc += 4 (wraps at 2^DATA_WIDTH); inflight <= 1, else 0.
//  Latency: req at T -> imem_instr_i sampled at T+1 -> entry on instr_valid_o at T+2. Steady state 1 instr/cycle.
//  Queue: FIFO of {pc, instr}; push and pop in same cycle legal, including at full and at single-entry.
//  instr_valid_o = !empty && !redirect_i; handshake during a redirect cycle never occurs.
//  Redirect at cycle N: queue flushed, in-flight response arriving at N+1 discarded, fetch_pc <= redirect_pc_i;
//   no request at N; first request at redirect target in N+1; first valid target instr at N+3.
//  Back-to-back redirects: last one wins; each flushes again.
//  Reset mid-run: any queued/in-flight data dropped; response arriving the cycle after rst ignored.
//  Never overflows: issue credit counts in-flight; push at full is a design error (assertion).
// STRUCTURE
//  fetch_pkg: NOP_INSTR constant, fetch_state_e {IDLE, RUN}, fetch_entry_t {pc, instr}.
//  Sub-module fetch_queue: sync FIFO of fetch_entry_t, params DEPTH; ports push/pop/flush/count/empty/full/head.
//  fetch_unit: FSM, fetch_pc register, inflight/kill flag, issue-credit logic, output muxing.
// TESTING
//  1 Reset, trigger_i=0 for 10 cycles -> imem_req_o stays 0, instr_valid_o=0, instr_o=32'h13, running_o=0.
//  2 trigger_i pulse at cycle 3, ready=1 -> req addr 0,4,8,... from cycle 4; pc_o=0 valid cycle 6, then +4 each cycle.
//  3 ready=0 with DEPTH=4 -> exactly 4 requests issued, occupancy_o=4, req low; ready=1 -> drains in order, resumes.
//  4 redirect_i at N to 32'h0000_0103 with req in flight -> next req addr 32'h100 at N+1, pc_o=32'h100 valid at N+3, no stale entries.
//  5 RESET_PC=32'hFFFF_FFF8 -> fetch addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus_4_o at FFFF_FFFC = 0.
//  6 rst asserted with full queue + in-flight -> next cycle all outputs at reset values; returns IDLE until new trigger.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, instr} entries with single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_W);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this same cycle, so push at full is fine alongside it.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full && !do_pop));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: run/idle FSM, credit-limited fetch issue to a
// 1-cycle sync instruction memory, prefetch queue, and redirect flushing.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           trigger_i,
  input  logic                           redirect_i,
  input  logic [DATA_WIDTH-1:0]          redirect_pc_i,
  output logic                           imem_req_o,
  output logic [DATA_WIDTH-1:0]          imem_addr_o,
  input  logic [DATA_WIDTH-1:0]          imem_instr_i,
  output logic                           instr_valid_o,
  input  logic                           instr_ready_i,
  output logic [DATA_WIDTH-1:0]          instr_o,
  output logic [DATA_WIDTH-1:0]          pc_o,
  output logic [DATA_WIDTH-1:0]          pc_plus_4_o,
  output logic                           running_o,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy_o
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } slot_t;

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q;
  logic [DATA_WIDTH-1:0] inflight_pc_q;
  logic                  inflight_q;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [CW:0]           credit;
  slot_t                 push_entry;
  slot_t                 q_head;
  logic [CW-1:0]         q_count;
  logic                  q_empty;
  logic                  q_full;

  // Slots already committed once this cycle's pop and the pending response settle.
  assign credit = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        issue = !redirect_i && (credit < DEPTH_W);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
      end
      if (redirect_i) begin
        fetch_pc_q <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      end else if (issue) begin
        fetch_pc_q <= fetch_pc_q + DATA_WIDTH'(4);
      end
    end
  end

  // A response landing during a redirect belongs to the wrong path.
  assign push             = inflight_q && !redirect_i;
  assign push_entry.pc    = inflight_pc_q;
  assign push_entry.instr = imem_instr_i;

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (slot_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign instr_valid_o = !q_empty && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = instr_valid_o ? q_head.instr : DATA_WIDTH'(NOP_INSTR);
  assign pc_o        = instr_valid_o ? q_head.pc : '0;
  assign pc_plus_4_o = pc_o + DATA_WIDTH'(4);
  assign running_o   = (state_q == RUN);
  assign occupancy_o = q_count + CW'(inflight_q);

  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, start, back-pressure, redirects,
// address wrap and mid-run reset, with an address-derived instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        trig;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;

  logic        req,  req1;
  logic [31:0] addr, addr1;
  logic [31:0] imem, imem1;
  logic        valid, valid1;
  logic [31:0] instr, instr1;
  logic [31:0] pc, pc1;
  logic [31:0] pc4, pc41;
  logic        running, running1;
  logic [2:0]  occ, occ1;

  int checks;
  int failures;

  fetch_unit #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (4)
  ) u0 (
    .clk           (clk),
    .rst           (rst),
    .trigger_i     (trig),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_instr_i  (imem),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus_4_o   (pc4),
    .running_o     (running),
    .occupancy_o   (occ)
  );

  fetch_unit #(
    .DATA_WIDTH  (32),
    .RESET_PC    (32'hFFFF_FFF8),
    .QUEUE_DEPTH (4)
  ) u1 (
    .clk           (clk),
    .rst           (rst),
    .trigger_i     (trig),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .imem_req_o    (req1),
    .imem_addr_o   (addr1),
    .imem_instr_i  (imem1),
    .instr_valid_o (valid1),
    .instr_ready_i (1'b1),
    .instr_o       (instr1),
    .pc_o          (pc1),
    .pc_plus_4_o   (pc41),
    .running_o     (running1),
    .occupancy_o   (occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns C0DE_0000 ^ addr one cycle after a request.
  always @(posedge clk) begin
    imem  <= req  ? (32'hC0DE_0000 ^ addr)  : 32'hDEAD_BEEF;
    imem1 <= req1 ? (32'hC0DE_0000 ^ addr1) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; trig = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0; #1;

    chk("rst_req",      32'(req),      32'h0);
    chk("rst_addr",     addr,          32'h0);
    chk("rst_addr1",    addr1,         32'hFFFF_FFF8);
    chk("rst_valid",    32'(valid),    32'h0);
    chk("rst_instr",    instr,         32'h0000_0013);
    chk("rst_pc",       pc,            32'h0);
    chk("rst_running",  32'(running),  32'h0);
    chk("rst_occ",      32'(occ),      32'h0);
    chk("rst_req1",     32'(req1),     32'h0);
    chk("rst_valid1",   32'(valid1),   32'h0);
    chk("rst_running1", 32'(running1), 32'h0);
    chk("rst_occ1",     32'(occ1),     32'h0);

    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("idle_req",     32'(req),     32'h0);
      chk("idle_valid",   32'(valid),   32'h0);
      chk("idle_instr",   instr,        32'h0000_0013);
      chk("idle_running", 32'(running), 32'h0);
    end

    // Start pulse (cycle A).
    cyc(); trig = 1'b1; #1;
    chk("a_running", 32'(running), 32'h0);
    cyc(); trig = 1'b0; #1;
    chk("a1_running", 32'(running), 32'h1);
    chk("a1_req",     32'(req),     32'h1);
    chk("a1_addr",    addr,         32'h0);
    chk("a1_valid",   32'(valid),   32'h0);
    chk("a1_addr1",   addr1,        32'hFFFF_FFF8);
    cyc(); #1;
    chk("a2_addr",    addr,         32'h4);
    chk("a2_valid",   32'(valid),   32'h0);
    chk("a2_addr1",   addr1,        32'hFFFF_FFFC);
    cyc(); #1;
    chk("a3_addr",    addr,         32'h8);
    chk("a3_valid",   32'(valid),   32'h1);
    chk("a3_pc",      pc,           32'h0);
    chk("a3_instr",   instr,        32'hC0DE_0000);
    chk("a3_pc4",     pc4,          32'h4);
    chk("a3_addr1",   addr1,        32'h0000_0000);
    chk("a3_pc1",     pc1,          32'hFFFF_FFF8);
    cyc(); #1;
    chk("a4_addr",    addr,         32'hC);
    chk("a4_pc",      pc,           32'h4);
    chk("a4_pc1",     pc1,          32'hFFFF_FFFC);
    chk("a4_instr1",  instr1,       32'h3F21_FFFC);
    chk("a4_pc41",    pc41,         32'h0);

    // Back-pressure: queue fills to 4 and requests stop.
    cyc(); ready = 1'b0; #1;
    chk("bp0_req",  32'(req), 32'h1);
    chk("bp0_addr", addr,     32'h10);
    cyc(); #1;
    chk("bp1_req",  32'(req), 32'h1);
    chk("bp1_addr", addr,     32'h14);
    cyc(); #1;
    chk("bp2_req",  32'(req), 32'h0);
    chk("bp2_occ",  32'(occ), 32'h4);
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("bp_hold_req",   32'(req),   32'h0);
      chk("bp_hold_occ",   32'(occ),   32'h4);
      chk("bp_hold_valid", 32'(valid), 32'h1);
      chk("bp_hold_pc",    pc,         32'h8);
    end

    // Drain in order and resume.
    cyc(); ready = 1'b1; #1;
    chk("dr0_pc",   pc,       32'h8);
    chk("dr0_req",  32'(req), 32'h1);
    chk("dr0_addr", addr,     32'h18);
    cyc(); #1;
    chk("dr1_pc",   pc,       32'hC);
    chk("dr1_addr", addr,     32'h1C);
    cyc(); #1;
    chk("dr2_pc",   pc,       32'h10);
    chk("dr2_addr", addr,     32'h20);
    cyc(); #1;
    chk("dr3_pc",   pc,       32'h14);
    cyc(); #1;
    chk("dr4_pc",   pc,       32'h18);
    chk("dr4_instr", instr,   32'hC0DE_0018);
    cyc(); #1;
    chk("dr5_pc",   pc,       32'h1C);

    // Redirect with a request in flight.
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("rd0_req",   32'(req),   32'h0);
    chk("rd0_valid", 32'(valid), 32'h0);
    chk("rd0_instr", instr,      32'h0000_0013);
    chk("rd0_pc",    pc,         32'h0);
    cyc(); redirect = 1'b0; #1;
    chk("rd1_req",   32'(req),   32'h1);
    chk("rd1_addr",  addr,       32'h100);
    chk("rd1_valid", 32'(valid), 32'h0);
    chk("rd1_occ",   32'(occ),   32'h0);
    cyc(); #1;
    chk("rd2_addr",  addr,       32'h104);
    chk("rd2_valid", 32'(valid), 32'h0);
    cyc(); #1;
    chk("rd3_valid", 32'(valid), 32'h1);
    chk("rd3_pc",    pc,         32'h100);
    chk("rd3_instr", instr,      32'hC0DE_0100);
    chk("rd3_pc4",   pc4,        32'h104);
    cyc(); #1;
    chk("rd4_pc",    pc,         32'h104);

    // Back-to-back redirects: the second target wins.
    cyc(); redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("bb0_req",   32'(req),   32'h0);
    cyc(); redirect_pc = 32'h300; #1;
    chk("bb1_req",   32'(req),   32'h0);
    chk("bb1_valid", 32'(valid), 32'h0);
    cyc(); redirect = 1'b0; #1;
    chk("bb2_req",   32'(req),   32'h1);
    chk("bb2_addr",  addr,       32'h300);
    cyc(); #1;
    chk("bb3_valid", 32'(valid), 32'h0);
    chk("bb3_addr",  addr,       32'h304);
    cyc(); #1;
    chk("bb4_valid", 32'(valid), 32'h1);
    chk("bb4_pc",    pc,         32'h300);
    chk("bb4_instr", instr,      32'hC0DE_0300);

    // Reset with queued entries and a request in flight.
    cyc(); ready = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    chk("mr_occ", 32'(occ), 32'h4);
    chk("mr_req", 32'(req), 32'h0);
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    chk("mr_req0",     32'(req),     32'h0);
    chk("mr_addr0",    addr,         32'h0);
    chk("mr_valid0",   32'(valid),   32'h0);
    chk("mr_instr0",   instr,        32'h0000_0013);
    chk("mr_pc0",      pc,           32'h0);
    chk("mr_running0", 32'(running), 32'h0);
    chk("mr_occ0",     32'(occ),     32'h0);
    chk("mr_addr1",    addr1,        32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("mr_idle_valid",   32'(valid),   32'h0);
      chk("mr_idle_req",     32'(req),     32'h0);
      chk("mr_idle_running", 32'(running), 32'h0);
      chk("mr_idle_occ",     32'(occ),     32'h0);
    end

    // Restart after reset.
    cyc(); ready = 1'b1; trig = 1'b1; #1;
    cyc(); trig = 1'b0; #1;
    chk("rs1_req",  32'(req), 32'h1);
    chk("rs1_addr", addr,     32'h0);
    cyc(); #1;
    chk("rs2_valid", 32'(valid), 32'h0);
    cyc(); #1;
    chk("rs3_valid", 32'(valid), 32'h1);
    chk("rs3_pc",    pc,         32'h0);
    chk("rs3_instr", instr,      32'hC0DE_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
